// File: rtl/velocity_cell_pingpong_if.sv
// Velocity cell ping-pong memory bus.
// Read, shadow-write and swap channels plus bank status.
interface velocity_cell_pingpong_if #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8
);
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_oor;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_err;
    logic                  swap_req;
    logic                  swap_done;
    logic                  active_bank;
    logic [ADDR_WIDTH-1:0] active_count;
    logic [ADDR_WIDTH-1:0] shadow_count;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, swap_req,
        input  rd_valid, rd_data, rd_oor, wr_err, swap_done,
        input  active_bank, active_count, shadow_count
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, swap_req,
        output rd_valid, rd_data, rd_oor, wr_err, swap_done,
        output active_bank, active_count, shadow_count
    );
endinterface

// File: rtl/velocity_cell_pingpong.sv
// Double-buffered velocity cell memory.
// Active bank serves reads, shadow bank takes updates, swap exchanges them.
module velocity_cell_pingpong #(
    parameter int DATA_WIDTH   = 96,
    parameter int PARTICLE_NUM = 220,
    parameter int ADDR_WIDTH   = 8
) (
    input logic                    clk,
    input logic                    rst,
    velocity_cell_pingpong_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] NUM =
        (ADDR_WIDTH + 1)'(PARTICLE_NUM);
    localparam logic [ADDR_WIDTH-1:0] MAX_CNT =
        ADDR_WIDTH'(PARTICLE_NUM - 1);

    logic [DATA_WIDTH-1:0] mem0 [PARTICLE_NUM];
    logic [DATA_WIDTH-1:0] mem1 [PARTICLE_NUM];

    logic                  bank;
    logic [ADDR_WIDTH-1:0] act_cnt;
    logic [ADDR_WIDTH-1:0] shd_cnt;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_oor;
    logic                  wr_err;
    logic                  swap_done;

    logic                  wr_ok;
    logic                  wr_cnt_ld;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic                  rd_hit;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic [ADDR_WIDTH-1:0] wr_idx;
    logic [DATA_WIDTH-1:0] rd_word;

    // Decode write legality, saturated count and read range.
    always_comb begin
        wr_ok     = bus.wr_en && ({1'b0, bus.wr_addr} < NUM);
        wr_cnt_ld = wr_ok && (bus.wr_addr == '0);
        wr_cnt    = bus.wr_data[ADDR_WIDTH-1:0];
        if (wr_cnt > MAX_CNT)
            wr_cnt = MAX_CNT;
        rd_hit = (bus.rd_addr != '0)
              && (bus.rd_addr <= act_cnt)
              && ({1'b0, bus.rd_addr} < NUM);
        rd_idx  = rd_hit ? bus.rd_addr : '0;
        wr_idx  = wr_ok ? bus.wr_addr : '0;
        rd_word = bank ? mem1[rd_idx] : mem0[rd_idx];
    end

    // Bank 0 storage: written only while it is the shadow bank.
    always_ff @(posedge clk) begin
        if (wr_ok && bank)
            mem0[wr_idx] <= bus.wr_data;
    end

    // Bank 1 storage: written only while it is the shadow bank.
    always_ff @(posedge clk) begin
        if (wr_ok && !bank)
            mem1[wr_idx] <= bus.wr_data;
    end

    // Bank select and per-bank counts; counts follow their banks on swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank    <= 1'b0;
            act_cnt <= '0;
            shd_cnt <= '0;
        end else if (bus.swap_req) begin
            bank    <= !bank;
            act_cnt <= wr_cnt_ld ? wr_cnt : shd_cnt;
            shd_cnt <= act_cnt;
        end else if (wr_cnt_ld) begin
            shd_cnt <= wr_cnt;
        end
    end

    // Registered read port; address 0 returns the active count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_oor   <= 1'b0;
        end else begin
            rd_valid <= bus.rd_en;
            if (bus.rd_en) begin
                if (bus.rd_addr == '0) begin
                    rd_data <= {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, act_cnt};
                    rd_oor  <= 1'b0;
                end else if (rd_hit) begin
                    rd_data <= rd_word;
                    rd_oor  <= 1'b0;
                end else begin
                    rd_data <= '0;
                    rd_oor  <= 1'b1;
                end
            end
        end
    end

    // One-cycle status pulses for dropped writes and completed swaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_err    <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            wr_err    <= bus.wr_en && !wr_ok;
            swap_done <= bus.swap_req;
        end
    end

    assign bus.rd_valid     = rd_valid;
    assign bus.rd_data      = rd_data;
    assign bus.rd_oor       = rd_oor;
    assign bus.wr_err       = wr_err;
    assign bus.swap_done    = swap_done;
    assign bus.active_bank  = bank;
    assign bus.active_count = act_cnt;
    assign bus.shadow_count = shd_cnt;
endmodule
